dcd_scan: RTL and testbench
===========================

Name: dcd_scan

Overview:
- Registered, parametrised N-to-2^N one-hot decoder with an auto-scan mode, for driving multiplexed display digits or row strobes.
- Manual mode decodes an external select code. Scan mode steps an internal code through all 2^N outputs at a programmable rate.
- Keeps the team's decoder output ordering: code 0 asserts the MSB output line.

Parameters:
- SEL_W, 2, select/code width N; output width is 2^SEL_W; legal range 1..5.
- DIV, 4, clock cycles per scan step; legal range 1..65535.
- ACT_LOW, 0, 1 = all output lines are active-low (idle level 1, selected line 0).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- en  in  1  block enable; 0 = all output lines idle, state held
- mode  in  1  0 = manual decode, 1 = auto scan
- sel  in  SEL_W  manual select code; also the scan start code
- dout  out  2^SEL_W  one-hot decoded lines, polarity set by ACT_LOW
- code  out  SEL_W  code currently decoded onto dout
- wrap  out  1  one-cycle pulse when scan code wraps from max to 0

Behaviour:
- Everything updates on the rising edge of clk. rst has priority over all other inputs.
- Reset values:
  - state = IDLE; code = 0; prescaler = 0; wrap = 0.
  - dout = all idle (all 0, or all 1 if ACT_LOW).
- Decode rule: for code k, line index (2^SEL_W-1-k) is active and all other lines are idle. Exactly one line is active outside IDLE.
- States:
  - IDLE: entered on reset or whenever en=0. dout idle, code held, prescaler held, wrap=0.
    - en=1, mode=0 -> MANUAL.
    - en=1, mode=1 -> SCAN; on entry code<=sel and prescaler<=0.
  - MANUAL: each cycle code<=sel and dout<=decode(sel). Latency is 1 cycle from sel to dout. wrap=0.
    - en=0 -> IDLE.
    - mode=1 -> SCAN; on entry code<=sel and prescaler<=0.
  - SCAN: prescaler counts 0..DIV-1.
    - When prescaler==DIV-1: prescaler<=0 and code<=code+1, wrapping mod 2^SEL_W. Otherwise prescaler<=prescaler+1.
    - dout always reflects the registered code. Each code is held DIV cycles; with DIV=1 the code steps every cycle.
    - wrap=1 for exactly the cycle in which code becomes 0 because of a step from 2^SEL_W-1.
    - Entry into SCAN with sel=0 does not pulse wrap.
    - en=0 -> IDLE, with code and prescaler frozen.
    - mode=0 -> MANUAL; code<=sel on that edge.
- Resuming from IDLE always reloads code from sel. A paused scan does not continue from its frozen position.
- sel is ignored in SCAN except on the entry edge.
- Prescaler width is clog2(DIV), minimum 1 bit. No arithmetic overflow beyond the mod-2^SEL_W code wrap.
- rst asserted mid-scan: the next edge returns the reset values regardless of en/mode. No wrap pulse is generated.
- Simultaneous events: en=0 overrides mode and any pending scan step. rst overrides everything.

Test Plan:
- Reset: SEL_W=2, ACT_LOW=0, hold rst 2 cycles with en=1 -> dout=4'b0000, code=0, wrap=0. Release -> first decode appears 1 cycle later.
- Manual decode: en=1, mode=0, sel=0,1,2,3 on successive cycles -> dout=1000, 0100, 0010, 0001, each 1 cycle after sel; code tracks sel.
- Scan: DIV=4, mode=1, sel=2 -> code=2 for 4 cycles, then 3 for 4, then 0. wrap=1 only on the cycle code becomes 0, then 1, 2, ... (16-cycle period).
- Pause: mid-scan en=0 for 5 cycles -> dout=0000, wrap=0. Re-enable with sel=1 -> scan restarts at code=1, prescaler 0.
- ACT_LOW=1, SEL_W=3, DIV=1, scan from sel=0 -> dout=01111111, 10111111, ... one step per cycle. wrap pulses every 8 cycles. rst mid-scan -> dout=11111111 on the next edge.

Source files
------------

// File: rtl/dcd_scan_if.sv
// Bundles the decoder's control inputs and decoded outputs.
//   master : drives en/mode/sel, observes dout/code/wrap (bench or parent)
//   slave  : the dcd_scan block itself
// Signals:
//   en    block enable; 0 idles all output lines
//   mode  0 = manual decode, 1 = auto scan
//   sel   manual select code, also the scan start code
//   dout  one-hot decoded lines (2^SEL_W wide)
//   code  code currently decoded onto dout
//   wrap  one-cycle pulse when the scan code wraps from max to 0
interface dcd_scan_if #(
    parameter int SEL_W = 2
);
    localparam int OUT_W = 1 << SEL_W;

    logic             en;
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic [OUT_W-1:0] dout;
    logic [SEL_W-1:0] code;
    logic             wrap;

    modport master (
        output en, mode, sel,
        input  dout, code, wrap
    );

    modport slave (
        input  en, mode, sel,
        output dout, code, wrap
    );
endinterface

// File: rtl/dcd_scan.sv
// Registered N-to-2^N one-hot decoder with an auto-scan mode for multiplexed
// display digits or row strobes. Code 0 drives the MSB output line.
// Ports:
//   clk_i  rising-edge clock
//   rst_i  synchronous active-high reset
//   bus    dcd_scan_if slave modport (en, mode, sel in; dout, code, wrap out)
//
// state  | meaning
// IDLE   | outputs idle, code and prescaler frozen
// MANUAL | code follows sel every cycle
// SCAN   | code advances every DIV cycles, wrapping mod 2^SEL_W
module dcd_scan #(
    parameter int SEL_W   = 2,
    parameter int DIV     = 4,
    parameter bit ACT_LOW = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    dcd_scan_if.slave   bus
);
    localparam int OUT_W = 1 << SEL_W;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(DIV - 1);
    localparam logic [OUT_W-1:0] MSB_LINE = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] IDLE_LVL = ACT_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] code_q,  code_d;
    logic [PRE_W-1:0] pre_q,   pre_d;
    logic             wrap_q,  wrap_d;
    logic [OUT_W-1:0] dout_q,  dout_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            code_q  <= '0;
            pre_q   <= '0;
            wrap_q  <= 1'b0;
            dout_q  <= IDLE_LVL;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            pre_q   <= pre_d;
            wrap_q  <= wrap_d;
            dout_q  <= dout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        pre_d   = pre_q;
        wrap_d  = 1'b0;

        // en=0 wins over mode changes and any pending scan step
        if (!bus.en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, MANUAL: begin
                    code_d = bus.sel;
                    if (bus.mode) begin
                        state_d = SCAN;
                        pre_d   = '0;
                    end else begin
                        state_d = MANUAL;
                    end
                end
                SCAN: begin
                    if (!bus.mode) begin
                        state_d = MANUAL;
                        code_d  = bus.sel;
                    end else if (pre_q == PRE_MAX) begin
                        pre_d  = '0;
                        code_d = code_q + 1'b1;
                        wrap_d = (code_q == {SEL_W{1'b1}});
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // dout is registered alongside code so it always matches the code output
        if (state_d == IDLE) begin
            dout_d = IDLE_LVL;
        end else if (ACT_LOW) begin
            dout_d = ~(MSB_LINE >> code_d);
        end else begin
            dout_d = MSB_LINE >> code_d;
        end
    end

    assign bus.dout = dout_q;
    assign bus.code = code_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_dcd_scan.sv
module tb_dcd_scan;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    dcd_scan_if #(.SEL_W(2)) if_a ();
    dcd_scan_if #(.SEL_W(3)) if_b ();

    dcd_scan #(.SEL_W(2), .DIV(4), .ACT_LOW(1'b0)) u_dut_a (
        .clk_i (clk),
        .rst_i (rst_a),
        .bus   (if_a)
    );

    dcd_scan #(.SEL_W(3), .DIV(1), .ACT_LOW(1'b1)) u_dut_b (
        .clk_i (clk),
        .rst_i (rst_b),
        .bus   (if_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input int ec, input bit idle, input bit ew);
        logic [3:0] msb;
        logic [3:0] ed;
        msb = 4'b1000;
        ed  = idle ? 4'b0000 : (msb >> ec);
        chk({tag, ".code"}, 32'(if_a.code), 32'(ec));
        chk({tag, ".dout"}, 32'(if_a.dout), 32'(ed));
        chk({tag, ".wrap"}, 32'(if_a.wrap), 32'(ew));
    endtask

    task automatic chk_b(input string tag, input int ec, input bit idle, input bit ew);
        logic [7:0] msb;
        logic [7:0] ed;
        msb = 8'h80;
        ed  = idle ? 8'hFF : ~(msb >> ec);
        chk({tag, ".code"}, 32'(if_b.code), 32'(ec));
        chk({tag, ".dout"}, 32'(if_b.dout), 32'(ed));
        chk({tag, ".wrap"}, 32'(if_b.wrap), 32'(ew));
    endtask

    initial begin
        rst_a = 1'b1;  if_a.en = 1'b1; if_a.mode = 1'b0; if_a.sel = 2'd0;
        rst_b = 1'b1;  if_b.en = 1'b0; if_b.mode = 1'b0; if_b.sel = 3'd0;

        // ---- DUT A: SEL_W=2, DIV=4, active-high ----
        tick(); chk_a("a_rst0", 0, 1'b1, 1'b0);
        tick(); chk_a("a_rst1", 0, 1'b1, 1'b0);

        rst_a = 1'b0;
        for (int s = 0; s < 4; s++) begin
            if_a.sel = 2'(s);
            tick();
            chk_a("a_man", s, 1'b0, 1'b0);
        end

        // scan from 2; sel changes after entry must be ignored
        if_a.mode = 1'b1; if_a.sel = 2'd2;
        for (int t = 0; t < 20; t++) begin
            tick();
            if_a.sel = 2'd0;
            chk_a("a_scan", (2 + t / 4) % 4, 1'b0, (t > 0) && (t % 4 == 0) && (((2 + t / 4) % 4) == 0));
        end

        // pause while a step is pending (prescaler at DIV-1, code 2)
        if_a.en = 1'b0;
        for (int t = 0; t < 5; t++) begin
            tick();
            chk_a("a_pause", 2, 1'b1, 1'b0);
        end

        // resume reloads from sel with prescaler cleared
        if_a.en = 1'b1; if_a.sel = 2'd1;
        for (int t = 0; t < 16; t++) begin
            tick();
            chk_a("a_resume", (1 + t / 4) % 4, 1'b0, (t > 0) && (t % 4 == 0) && (((1 + t / 4) % 4) == 0));
        end

        // back to manual mode from scan
        if_a.mode = 1'b0; if_a.sel = 2'd3;
        tick(); chk_a("a_toman", 3, 1'b0, 1'b0);

        // ---- DUT B: SEL_W=3, DIV=1, active-low ----
        tick(); chk_b("b_rst", 0, 1'b1, 1'b0);
        rst_b = 1'b0; if_b.en = 1'b1; if_b.mode = 1'b1; if_b.sel = 3'd0;
        for (int t = 0; t < 24; t++) begin
            tick();
            chk_b("b_scan", t % 8, 1'b0, (t > 0) && (t % 8 == 0));
        end

        // code is 7 here: reset must win over the pending wrap
        rst_b = 1'b1;
        tick(); chk_b("b_rst_mid", 0, 1'b1, 1'b0);
        tick(); chk_b("b_rst_hold", 0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", n_chk);
        $fatal(1, "timeout");
    end
endmodule
